// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the memory arbiter state/owner encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_fairness_ctr.sv
// Saturating count of data grants taken while a fetch was waiting.
// force_i tells the arbiter the fetch side must win the next grant.
module arb_fairness_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic force_i
);

  localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

  logic [3:0] cnt;

  // Count data grants that bypassed a pending fetch; clear when fetch is not starved.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= 4'd0;
    end else if (inc) begin
      if (cnt < MAX_C) begin
        cnt <= cnt + 4'd1;
      end
    end else if (clr) begin
      cnt <= 4'd0;
    end
  end

  assign force_i = (cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data wins by default; a saturating counter forces a fetch grant after
// STARVE_MAX consecutive data grants taken while a fetch was pending.
import cpu_types_pkg::*;

module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output word_t             iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output word_t             dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  logic              ramready
);

  arb_state_t        state;
  arb_state_t        next_state;
  arb_owner_t        owner;
  logic              is_write;
  logic [ADDR_W-1:0] addr_q;
  word_t             store_q;
  logic              dreq;
  logic              grant_d;
  logic              grant_i;
  logic              force_i;
  logic              in_acc;

  assign dreq   = dREN | dWEN;
  assign in_acc = (state == IACC) || (state == DACC);

  arb_fairness_ctr #(.STARVE_MAX(STARVE_MAX)) u_fair (
    .CLK     (CLK),
    .nRST    (nRST),
    .inc     (grant_d & iREN),
    .clr     (grant_i | (grant_d & ~iREN)),
    .force_i (force_i)
  );

  // State register; reset abandons any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant decision in IDLE and access sequencing through DONE.
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && !(iREN && force_i)) begin
          next_state = DACC;
          grant_d    = 1'b1;
        end else if (iREN) begin
          next_state = IACC;
          grant_i    = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      IACC, DACC: begin
        if (ramready) begin
          next_state = DONE;
        end else begin
          next_state = state;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the granted request and capture read data on completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q   <= '0;
      store_q  <= 32'd0;
      is_write <= 1'b0;
      owner    <= OWN_I;
      iload    <= 32'd0;
      dload    <= 32'd0;
    end else begin
      if (grant_d) begin
        addr_q   <= daddr;
        store_q  <= dstore;
        is_write <= dWEN;
        owner    <= OWN_D;
      end else if (grant_i) begin
        addr_q   <= iaddr;
        is_write <= 1'b0;
        owner    <= OWN_I;
      end
      if (in_acc && ramready && !is_write) begin
        if (owner == OWN_I) begin
          iload <= ramload;
        end else begin
          dload <= ramload;
        end
      end
    end
  end

  assign ramREN   = (state == IACC) || ((state == DACC) && !is_write);
  assign ramWEN   = (state == DACC) && is_write;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  assign iwait = iREN & ~((state == DONE) && (owner == OWN_I));
  assign dwait = dreq & ~((state == DONE) && (owner == OWN_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the RAM.
import cpu_types_pkg::*;

module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0;
    #12;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_cnt", 32'(dut.u_fair.cnt), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    iREN = 1'b1; iaddr = 32'h40; ramready = 1'b0; #1;
    chk("sf_c0_iwait", 32'(iwait), 32'd1);
    chk("sf_c0_ramREN", 32'(ramREN), 32'd0);
    tick();
    ramready = 1'b1; ramload = 32'h8C220004; #1;
    chk("sf_c1_ramREN", 32'(ramREN), 32'd1);
    chk("sf_c1_ramaddr", ramaddr, 32'h40);
    chk("sf_c1_iwait", 32'(iwait), 32'd1);
    tick();
    ramready = 1'b0; ramload = 32'h0; #1;
    chk("sf_c2_iwait", 32'(iwait), 32'd0);
    chk("sf_c2_iload", iload, 32'h8C220004);
    chk("sf_c2_ramREN", 32'(ramREN), 32'd0);
    iREN = 1'b0;
    tick();
    chk("sf_c3_state", 32'(dut.state), 32'(IDLE));
    chk("sf_c3_iload_hold", iload, 32'h8C220004);
  endtask

  task automatic test_wait_states();
    dREN = 1'b1; daddr = 32'h100; ramready = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      ramready = (c == 4) ? 1'b1 : 1'b0;
      ramload  = (c == 4) ? 32'hDEADBEEF : 32'h0;
      #1;
      chk("ws_ramaddr", ramaddr, 32'h100);
      chk("ws_ramREN", 32'(ramREN), 32'd1);
      chk("ws_dwait_hi", 32'(dwait), 32'd1);
      tick();
    end
    ramready = 1'b0; ramload = 32'h0; #1;
    chk("ws_c5_dwait", 32'(dwait), 32'd0);
    chk("ws_c5_dload", dload, 32'hDEADBEEF);
    chk("ws_c5_iload_kept", iload, 32'h8C220004);
    dREN = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h108;
    tick();
    ramready = 1'b1; ramload = 32'h11; #1;
    chk("sim_c1_state", 32'(dut.state), 32'(DACC));
    chk("sim_c1_ramaddr", ramaddr, 32'h108);
    chk("sim_c1_iwait", 32'(iwait), 32'd1);
    tick();
    ramready = 1'b0; #1;
    chk("sim_c2_dwait", 32'(dwait), 32'd0);
    chk("sim_c2_iwait", 32'(iwait), 32'd1);
    chk("sim_c2_dload", dload, 32'h11);
    dREN = 1'b0;
    tick();
    chk("sim_c3_state", 32'(dut.state), 32'(IDLE));
    chk("sim_c3_cnt", 32'(dut.u_fair.cnt), 32'd1);
    tick();
    ramready = 1'b1; ramload = 32'h22; #1;
    chk("sim_c4_state", 32'(dut.state), 32'(IACC));
    chk("sim_c4_ramaddr", ramaddr, 32'h44);
    tick();
    ramready = 1'b0; #1;
    chk("sim_c5_iwait", 32'(iwait), 32'd0);
    chk("sim_c5_iload", iload, 32'h22);
    chk("sim_c5_cnt", 32'(dut.u_fair.cnt), 32'd0);
    iREN = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int d_before_i = 0;
    int i_grants   = 0;
    int max_cnt    = 0;
    logic [31:0] last_d = 32'h0;
    logic done = 1'b0;
    iREN = 1'b1; iaddr = 32'h48; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h200;
    ramready = 1'b1; ramload = 32'hFFFF0000;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (int'(dut.u_fair.cnt) > max_cnt) max_cnt = int'(dut.u_fair.cnt);
      if (ramWEN && i_grants == 0) begin
        d_before_i++;
        last_d = ramaddr;
      end
      if (ramREN && ramaddr == 32'h48) begin
        i_grants++;
        chk("st_cnt_at_igrant", 32'(dut.u_fair.cnt), 32'd0);
      end
      if (!iwait) begin
        done = 1'b1;
        iREN = 1'b0; dWEN = 1'b0;
      end else if (!dwait) begin
        daddr  = daddr + 32'd4;
        dstore = daddr;
      end
      tick();
    end
    chk("st_done", 32'(done), 32'd1);
    chk("st_d_grants", 32'(d_before_i), 32'd4);
    chk("st_i_grants", 32'(i_grants), 32'd1);
    chk("st_last_daddr", last_d, 32'h20C);
    chk("st_max_cnt", 32'(max_cnt), 32'd4);
    chk("st_cnt_final", 32'(dut.u_fair.cnt), 32'd0);
    chk("st_dload_kept", dload, 32'h11);
    ramready = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int lows = 0;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678; ramready = 1'b0; #1;
    if (!dwait) lows++;
    tick();
    ramready = 1'b1; ramload = 32'hFFFFFFFF; #1;
    if (!dwait) lows++;
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramstore", ramstore, 32'h12345678);
    chk("wr_ramaddr", ramaddr, 32'h80);
    tick();
    ramready = 1'b0; #1;
    if (!dwait) lows++;
    chk("wr_dwait_pulses", 32'(lows), 32'd1);
    chk("wr_dload_unchanged", dload, 32'h11);
    dWEN = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'hA5A5A5A5; ramready = 1'b0;
    tick();
    chk("rm_ramWEN_before", 32'(ramWEN), 32'd1);
    nRST = 1'b0; #1;
    chk("rm_ramWEN_async", 32'(ramWEN), 32'd0);
    chk("rm_ramREN_async", 32'(ramREN), 32'd0);
    chk("rm_state", 32'(dut.state), 32'(IDLE));
    chk("rm_dload", dload, 32'd0);
    dWEN = 1'b0; #2;
    nRST = 1'b1;
    tick();
    chk("rm_state_after", 32'(dut.state), 32'(IDLE));
    chk("rm_ramWEN_after", 32'(ramWEN), 32'd0);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_wait_states();
    test_simultaneous();
    test_starvation();
    test_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
